// File: rtl/fb_write_arbiter.sv
// Shares one GPU pixel write port between a paint requester and a full-panel clear sweeper.
// Write pulses one cycle after grant, with WR_GAP idle cycles between grants; paint stalls through a_ready.
module fb_write_arbiter #(
  parameter int WR_GAP     = 1,
  parameter int CLR_PIXELS = 4096
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       a_valid,
  input  logic [5:0] a_x,
  input  logic [5:0] a_y,
  input  logic [7:0] a_data,
  input  logic       a_overlay,
  input  logic       a_palette,
  output logic       a_ready,
  input  logic       clear_start,
  input  logic [7:0] clear_data,
  input  logic       clear_overlay,
  output logic       clear_busy,
  output logic       clear_done,
  output logic       write,
  output logic [5:0] column,
  output logic [5:0] row,
  output logic [7:0] px_data,
  output logic       image_overlay,
  output logic       image_palette
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [11:0] CLR_LAST = 12'(CLR_PIXELS - 1);
  localparam logic [7:0]  GAP_LOAD = 8'(WR_GAP);

  state_t      state;
  logic [7:0]  gap_cnt;
  logic [11:0] clr_cnt;
  logic        last_paint;
  logic [7:0]  cl_data;
  logic        cl_ovl;

  logic slot_free;
  logic paint_grant;
  logic clear_grant;
  logic last_clear;

  // After a paint grant during a clear, the next slot belongs to the sweeper.
  assign slot_free   = (gap_cnt == 8'd0);
  assign a_ready     = slot_free && !((state == CLEAR) && last_paint);
  assign paint_grant = a_valid && a_ready;
  assign clear_grant = (state == CLEAR) && slot_free && !paint_grant;
  assign last_clear  = clear_grant && (clr_cnt == CLR_LAST);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state         <= IDLE;
      gap_cnt       <= 8'd0;
      clr_cnt       <= 12'd0;
      last_paint    <= 1'b0;
      cl_data       <= 8'd0;
      cl_ovl        <= 1'b0;
      write         <= 1'b0;
      column        <= 6'd0;
      row           <= 6'd0;
      px_data       <= 8'd0;
      image_overlay <= 1'b0;
      image_palette <= 1'b0;
      clear_busy    <= 1'b0;
      clear_done    <= 1'b0;
    end else begin
      write      <= paint_grant || clear_grant;
      clear_done <= last_clear;
      // Busy covers the whole sweep including the cycle clear_done is shown.
      clear_busy <= (state == CLEAR) || clear_start;

      if (paint_grant || clear_grant) begin
        gap_cnt <= GAP_LOAD;
      end else if (gap_cnt != 8'd0) begin
        gap_cnt <= gap_cnt - 8'd1;
      end

      if (paint_grant) begin
        last_paint    <= 1'b1;
        column        <= a_x;
        row           <= a_y;
        px_data       <= a_data;
        image_overlay <= a_overlay;
        image_palette <= a_palette;
      end else if (clear_grant) begin
        last_paint    <= 1'b0;
        column        <= clr_cnt[5:0];
        row           <= clr_cnt[11:6];
        px_data       <= cl_data;
        image_overlay <= cl_ovl;
        image_palette <= 1'b0;
        clr_cnt       <= clr_cnt + 12'd1;
      end

      case (state)
        IDLE: begin
          if (clear_start) begin
            state   <= CLEAR;
            cl_data <= clear_data;
            cl_ovl  <= clear_overlay;
            clr_cnt <= 12'd0;
          end
        end
        CLEAR: begin
          if (last_clear) begin
            state   <= IDLE;
            clr_cnt <= 12'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
